operand_fetch_sched: RTL and testbench

Read-burst scheduler that fills the five RSA operand FIFOs (R2, N, M, phi_N, Ei) from the shared operand SRAM. The AXI4 slave port of the SRAM interface has one master and five consumers. This block arbitrates among the consumers, round-robin, issuing one AXI4 INCR read burst at a time. It steers the returned beats into the granted channel's FIFO. It sits between the RSA control/register logic (which programs base/length per operand) and the SRAM/FIFO buffer pair.

---
 rtl/operand_fetch_sched.sv | 259 +++++++++++++++++++++++++
 tb/tb_operand_fetch_sched.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_sched.sv
// Round-robin AXI4 read-burst scheduler that fills the five RSA operand FIFOs.
// Build option: define FETCH_ERR_ABORT_EN to end a channel at the rlast of any errored burst.

module operand_fetch_sched_chk #(
    parameter int ADDR_WIDTH = 32,
    parameter int BPB        = 4
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  arvalid,
    input logic                  arready,
    input logic [ADDR_WIDTH-1:0] araddr,
    input logic [7:0]            arlen,
    input logic [3:0]            arid,
    input logic                  rvalid,
    input logic                  rready,
    input logic [3:0]            rid
);
    ar_stable: assert property (@(posedge clk) disable iff (rst)
        (arvalid && !arready) |=> (arvalid && $stable(araddr) && $stable(arlen) && $stable(arid)));

    no_4k_cross: assert property (@(posedge clk) disable iff (rst)
        arvalid |-> (({20'd0, araddr[11:0]} + ({24'd0, arlen} + 32'd1) * BPB) <= 32'd4096));

    rid_match: assert property (@(posedge clk) disable iff (rst)
        (rvalid && rready) |-> (rid == arid));
endmodule

module operand_fetch_sched #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4:0]                cfg_start,
    input  logic [5*ADDR_WIDTH-1:0]   cfg_base,
    input  logic [5*LEN_WIDTH-1:0]    cfg_len,
    input  logic [4:0]                ch_afull,
    output logic [DATA_WIDTH-1:0]     fifo_din,
    output logic [4:0]                fifo_wr_en,
    output logic [4:0]                ch_active,
    output logic [4:0]                ch_done,
    output logic [4:0]                ch_err,
    output logic                      busy,
    output logic [3:0]                m_axi_arid,
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [3:0]                m_axi_rid,
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);
    localparam int NCH  = 5;
    localparam int BPB  = DATA_WIDTH / 8;
    localparam int SIZE = $clog2(BPB);
`ifdef FETCH_ERR_ABORT_EN
    localparam logic ABORT_EN = 1'b1;
`else
    localparam logic ABORT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ARB = 2'd1, ST_ADDR = 2'd2, ST_DATA = 2'd3} state_t;

    state_t                 state_r;
    logic [ADDR_WIDTH-1:0]  addr_r [NCH];
    logic [LEN_WIDTH-1:0]   rem_r  [NCH];
    logic [NCH-1:0]         active_r, err_r, done_pend_r, ch_done_r, fifo_wr_en_r;
    logic [2:0]             grant_r, last_grant_r;
    logic [8:0]             beats_r;
    logic                   burst_err_r;
    logic [DATA_WIDTH-1:0]  fifo_din_r;
    logic [ADDR_WIDTH-1:0]  araddr_r;
    logic [7:0]             arlen_r;
    logic [3:0]             arid_r;
    logic                   arvalid_r, rready_r;

    logic [NCH-1:0]         start_ok_s, zero_len_s, elig_s, grant_onehot_s;
    logic                   found_s, beat_err_s, abort_s;
    logic [2:0]             pick_s;
    logic [12:0]            room_s;
    logic [8:0]             lim_s, beats_s;
    logic [LEN_WIDTH-1:0]   rem_after_s;
    logic [ADDR_WIDTH-1:0]  addr_step_s;

    // Start qualification and zero-length detection per channel
    always_comb begin
        start_ok_s = cfg_start & ~active_r;
        zero_len_s = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            zero_len_s[i] = (cfg_len[i*LEN_WIDTH +: LEN_WIDTH] == {LEN_WIDTH{1'b0}});
        end
    end

    // Round-robin pick: first eligible channel after the previous grant
    always_comb begin
        int idx;
        idx     = 0;
        elig_s  = active_r & ~ch_afull;
        found_s = 1'b0;
        pick_s  = 3'd0;
        for (int k = 1; k <= NCH; k++) begin
            idx = int'(last_grant_r) + k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end else begin
                idx = idx;
            end
            if (!found_s && elig_s[idx]) begin
                found_s = 1'b1;
                pick_s  = 3'(idx);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Burst length: limited by words left, MAX_BURST, and room to the next 4 KB page
    always_comb begin
        room_s  = (13'd4096 - {1'b0, addr_r[pick_s][11:0]}) >> SIZE;
        lim_s   = (32'(room_s) < 32'(MAX_BURST)) ? room_s[8:0] : 9'(MAX_BURST);
        beats_s = (32'(rem_r[pick_s]) < 32'(lim_s)) ? rem_r[pick_s][8:0] : lim_s;
    end

    // Per-beat bookkeeping for the granted channel
    always_comb begin
        grant_onehot_s = 5'b00001 << grant_r;
        beat_err_s     = (m_axi_rresp != 2'b00);
        abort_s        = ABORT_EN & (burst_err_r | beat_err_s);
        rem_after_s    = rem_r[grant_r] - {{(LEN_WIDTH-9){1'b0}}, beats_r};
        addr_step_s    = {{(ADDR_WIDTH-9){1'b0}}, beats_r} << SIZE;
    end

    // Channel registers, scheduler FSM and registered AXI/FIFO outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            for (int i = 0; i < NCH; i++) begin
                addr_r[i] <= {ADDR_WIDTH{1'b0}};
                rem_r[i]  <= {LEN_WIDTH{1'b0}};
            end
            active_r     <= {NCH{1'b0}};
            err_r        <= {NCH{1'b0}};
            done_pend_r  <= {NCH{1'b0}};
            ch_done_r    <= {NCH{1'b0}};
            fifo_wr_en_r <= {NCH{1'b0}};
            grant_r      <= 3'd0;
            last_grant_r <= 3'd4;
            beats_r      <= 9'd0;
            burst_err_r  <= 1'b0;
            fifo_din_r   <= {DATA_WIDTH{1'b0}};
            araddr_r     <= {ADDR_WIDTH{1'b0}};
            arlen_r      <= 8'd0;
            arid_r       <= 4'd0;
            arvalid_r    <= 1'b0;
            rready_r     <= 1'b0;
        end else begin
            ch_done_r    <= done_pend_r | (start_ok_s & zero_len_s);
            done_pend_r  <= {NCH{1'b0}};
            fifo_wr_en_r <= {NCH{1'b0}};
            for (int i = 0; i < NCH; i++) begin
                if (start_ok_s[i]) begin
                    addr_r[i]   <= cfg_base[i*ADDR_WIDTH +: ADDR_WIDTH];
                    rem_r[i]    <= cfg_len[i*LEN_WIDTH +: LEN_WIDTH];
                    active_r[i] <= ~zero_len_s[i];
                    err_r[i]    <= 1'b0;
                end
            end
            case (state_r)
                ST_IDLE: begin
                    state_r <= (|active_r) ? ST_ARB : ST_IDLE;
                end
                ST_ARB: begin
                    if (found_s) begin
                        grant_r      <= pick_s;
                        last_grant_r <= pick_s;
                        beats_r      <= beats_s;
                        araddr_r     <= addr_r[pick_s];
                        arlen_r      <= 8'(beats_s - 9'd1);
                        arid_r       <= {1'b0, pick_s};
                        arvalid_r    <= 1'b1;
                        burst_err_r  <= 1'b0;
                        state_r      <= ST_ADDR;
                    end else if (!(|active_r)) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_ARB;
                    end
                end
                ST_ADDR: begin
                    if (m_axi_arready) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state_r   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (m_axi_rvalid) begin
                        fifo_din_r   <= m_axi_rdata;
                        fifo_wr_en_r <= grant_onehot_s;
                        if (beat_err_s) begin
                            err_r[grant_r] <= 1'b1;
                            burst_err_r    <= 1'b1;
                        end
                        if (m_axi_rlast) begin
                            rready_r        <= 1'b0;
                            addr_r[grant_r] <= addr_r[grant_r] + addr_step_s;
                            if (abort_s || (rem_after_s == {LEN_WIDTH{1'b0}})) begin
                                rem_r[grant_r]       <= {LEN_WIDTH{1'b0}};
                                active_r[grant_r]    <= 1'b0;
                                done_pend_r[grant_r] <= 1'b1;
                            end else begin
                                rem_r[grant_r] <= rem_after_s;
                            end
                            state_r <= ST_ARB;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign fifo_din      = fifo_din_r;
    assign fifo_wr_en    = fifo_wr_en_r;
    assign ch_active     = active_r;
    assign ch_done       = ch_done_r;
    assign ch_err        = err_r;
    assign busy          = (|active_r) | (state_r != ST_IDLE);
    assign m_axi_arid    = arid_r;
    assign m_axi_araddr  = araddr_r;
    assign m_axi_arlen   = arlen_r;
    assign m_axi_arsize  = 3'(SIZE);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = arvalid_r;
    assign m_axi_rready  = rready_r;

    operand_fetch_sched_chk #(.ADDR_WIDTH(ADDR_WIDTH), .BPB(BPB)) u_chk (
        .clk     (clk),
        .rst     (rst),
        .arvalid (m_axi_arvalid),
        .arready (m_axi_arready),
        .araddr  (m_axi_araddr),
        .arlen   (m_axi_arlen),
        .arid    (m_axi_arid),
        .rvalid  (m_axi_rvalid),
        .rready  (m_axi_rready),
        .rid     (m_axi_rid)
    );
endmodule

// File: tb/tb_operand_fetch_sched.sv
// Self-checking bench for operand_fetch_sched: AXI read-slave model, write scoreboard,
// table of single-channel fetches plus hand sequences for arbitration, error and reset cases.
module tb_operand_fetch_sched;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [4:0]      cfg_start;
    logic [5*AW-1:0] cfg_base;
    logic [5*LW-1:0] cfg_len;
    logic [4:0]      ch_afull;
    logic [DW-1:0]   fifo_din;
    logic [4:0]      fifo_wr_en, ch_active, ch_done, ch_err;
    logic            busy;
    logic [3:0]      arid, rid;
    logic [AW-1:0]   araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst, rresp;
    logic            arvalid, arready, rlast, rvalid, rready;
    logic [DW-1:0]   rdata;

    operand_fetch_sched #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(16), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_base(cfg_base), .cfg_len(cfg_len),
        .ch_afull(ch_afull), .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .ch_active(ch_active),
        .ch_done(ch_done), .ch_err(ch_err), .busy(busy), .m_axi_arid(arid), .m_axi_araddr(araddr),
        .m_axi_arlen(arlen), .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arvalid(arvalid),
        .m_axi_arready(arready), .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [4:0] en; logic [31:0] d; } beat_t;
    typedef struct packed { logic [3:0] id; logic [31:0] addr; logic [7:0] len; } ar_t;
    typedef struct packed {
        logic [2:0] ch; logic [31:0] base; logic [15:0] len; logic [1:0] nb;
        logic [2:0][31:0] a; logic [2:0][7:0] l;
    } vec_t;

    beat_t exp_q[$];
    ar_t   ar_q[$];
    int    checks = 0, failures = 0, cyc = 0, arv_cyc = -1, start_ref = 0;
    int    wr_cnt[5], done_cnt[5], done_cyc[5], last_wr_cyc[5];
    logic  slave_kill = 1'b0, err_armed = 1'b0;
    int    err_ch = -1, err_beat = 0;
    vec_t  vecs[5];

    function automatic logic [31:0] pattern(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        beat_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (arvalid && arv_cyc < 0) arv_cyc = cyc;
            for (int i = 0; i < 5; i++) begin
                if (ch_done[i]) begin
                    done_cnt[i]++;
                    done_cyc[i] = cyc;
                    if (wr_cnt[i] > 0) chk("done_after_last_wr", 64'(cyc), 64'(last_wr_cyc[i] + 1));
                end
            end
            if (fifo_wr_en != 5'b00000) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_wr", 64'(fifo_wr_en), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_en", 64'(fifo_wr_en), 64'(e.en));
                    chk("wr_data", 64'(fifo_din), 64'(e.d));
                end
                for (int i = 0; i < 5; i++) begin
                    if (fifo_wr_en[i]) begin
                        wr_cnt[i]++;
                        last_wr_cyc[i] = cyc;
                    end
                end
            end
        end
    endtask

    task automatic slave();
        ar_t  a;
        logic ab;
        int   guard;
        forever begin
            @(negedge clk);
            if (arvalid && !slave_kill && !rst) begin
                if ($urandom_range(0, 2) == 0) @(negedge clk);
                a.id = arid; a.addr = araddr; a.len = arlen;
                arready = 1'b1;
                @(posedge clk); #1;
                arready = 1'b0;
                ar_q.push_back(a);
                ab = 1'b0;
                for (int b = 0; b <= int'(a.len) && !ab; b++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                    rvalid = 1'b1;
                    rid    = a.id;
                    rdata  = pattern(a.addr + 32'(4 * b));
                    rresp  = (err_armed && int'(a.id) == err_ch && b == err_beat) ? 2'b10 : 2'b00;
                    rlast  = (b == int'(a.len));
                    guard  = 0;
                    @(negedge clk);
                    while (!rready && !slave_kill && guard < 100) begin
                        guard++;
                        @(negedge clk);
                    end
                    if (slave_kill) begin
                        ab = 1'b1;
                    end else if (!rready) begin
                        chk("rready_timeout", 64'd0, 64'd1);
                        ab = 1'b1;
                    end else begin
                        @(posedge clk);
                        exp_q.push_back('{en: 5'(5'b00001 << a.id), d: rdata});
                        #1;
                    end
                    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
                end
                if (int'(a.id) == err_ch) err_armed = 1'b0;
            end
        end
    endtask

    task automatic clear_stats();
        exp_q.delete();
        ar_q.delete();
        for (int i = 0; i < 5; i++) begin
            wr_cnt[i] = 0; done_cnt[i] = 0; done_cyc[i] = -1; last_wr_cyc[i] = 0;
        end
        arv_cyc = -1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; cfg_start = 5'b00000; ch_afull = 5'b00000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_stats();
    endtask

    task automatic start_chs(input logic [4:0] mask, input logic [31:0] base,
                             input logic [15:0] len, input logic [31:0] stride);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            cfg_base[i*AW +: AW] = base + 32'(i) * stride;
            cfg_len[i*LW +: LW]  = len;
        end
        cfg_start = mask;
        @(posedge clk); #1;
        cfg_start = 5'b00000;
        start_ref = cyc;
    endtask

    task automatic wait_done(input int ch, input int n);
        int g = 0;
        while (done_cnt[ch] < n && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (done_cnt[ch] < n) chk("done_timeout", 64'(done_cnt[ch]), 64'(n));
    endtask

    task automatic chk_ids(input string name, input logic [4:0][3:0] ids, input int n);
        chk({name, "_ar_count"}, 64'(ar_q.size()), 64'(n));
        for (int j = 0; j < n; j++) begin
            if (j < ar_q.size()) chk({name, "_arid"}, 64'(ar_q[j].id), 64'(ids[j]));
        end
    endtask

    initial begin
        rst = 1'b1; cfg_start = 5'b00000; cfg_base = '0; cfg_len = '0; ch_afull = 5'b00000;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rid = 4'd0; rdata = 32'd0;
        vecs[0] = '{ch: 3'd0, base: 32'h000,  len: 16'd40, nb: 2'd3,
                    a: {32'h080, 32'h040, 32'h000}, l: {8'd7, 8'd15, 8'd15}};
        vecs[1] = '{ch: 3'd2, base: 32'hFF8,  len: 16'd8,  nb: 2'd2,
                    a: {32'h0, 32'h1000, 32'hFF8},  l: {8'd0, 8'd5, 8'd1}};
        vecs[2] = '{ch: 3'd3, base: 32'h100,  len: 16'd5,  nb: 2'd1,
                    a: {32'h0, 32'h0, 32'h100},     l: {8'd0, 8'd0, 8'd4}};
        vecs[3] = '{ch: 3'd1, base: 32'h2FC0, len: 16'd20, nb: 2'd2,
                    a: {32'h0, 32'h3000, 32'h2FC0}, l: {8'd0, 8'd3, 8'd15}};
        vecs[4] = '{ch: 3'd4, base: 32'h7FC,  len: 16'd1,  nb: 2'd1,
                    a: {32'h0, 32'h0, 32'h7FC},     l: {8'd0, 8'd0, 8'd0}};
        fork
            monitor();
            slave();
        join_none

        // reset values
        do_reset();
        @(negedge clk);
        chk("rst_fifo_wr_en", 64'(fifo_wr_en), 64'd0);
        chk("rst_fifo_din", 64'(fifo_din), 64'd0);
        chk("rst_ch_active", 64'(ch_active), 64'd0);
        chk("rst_ch_done", 64'(ch_done), 64'd0);
        chk("rst_ch_err", 64'(ch_err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ar", 64'({arvalid, arid, araddr, arlen}), 64'd0);
        chk("rst_rready", 64'(rready), 64'd0);
        chk("rst_arsize", 64'(arsize), 64'd2);
        chk("rst_arburst", 64'(arburst), 64'd1);

        // single-channel fetch table
        for (int v = 0; v < 5; v++) begin
            do_reset();
            start_chs(5'b00001 << vecs[v].ch, vecs[v].base, vecs[v].len, 32'd0);
            wait_done(int'(vecs[v].ch), 1);
            repeat (5) @(negedge clk);
            chk("start_to_arvalid", 64'(arv_cyc - start_ref), 64'd3);
            chk("vec_ar_count", 64'(ar_q.size()), 64'(vecs[v].nb));
            for (int j = 0; j < int'(vecs[v].nb); j++) begin
                if (j < ar_q.size()) begin
                    chk("vec_araddr", 64'(ar_q[j].addr), 64'(vecs[v].a[j]));
                    chk("vec_arlen", 64'(ar_q[j].len), 64'(vecs[v].l[j]));
                    chk("vec_arid", 64'(ar_q[j].id), 64'(vecs[v].ch));
                end
            end
            chk("vec_wr_count", 64'(wr_cnt[vecs[v].ch]), 64'(vecs[v].len));
            chk("vec_done_count", 64'(done_cnt[vecs[v].ch]), 64'd1);
            chk("vec_idle", 64'({busy, ch_active, ch_err}), 64'd0);
            chk("vec_sb_empty", 64'(exp_q.size()), 64'd0);
        end

        // all five channels at once: grants 0..4
        do_reset();
        start_chs(5'b11111, 32'h1000, 16'd16, 32'h100);
        for (int i = 0; i < 5; i++) wait_done(i, 1);
        repeat (5) @(negedge clk);
        chk_ids("all5", {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, 5);
        for (int i = 0; i < 5; i++) begin
            chk("all5_wr", 64'(wr_cnt[i]), 64'd16);
            if (i < ar_q.size()) chk("all5_addr", 64'(ar_q[i].addr), 64'(32'h1000 + 32'(i) * 32'h100));
        end

        // afull blocks ch1 until released
        do_reset();
        ch_afull = 5'b00010;
        start_chs(5'b01010, 32'h000, 16'd32, 32'h400);
        begin
            int g = 0;
            while (ar_q.size() < 1 && g < 200) begin
                @(negedge clk);
                g++;
            end
        end
        chk("afull_ch1_waiting", 64'(ch_active[1]), 64'd1);
        ch_afull = 5'b00000;
        wait_done(1, 1);
        wait_done(3, 1);
        repeat (5) @(negedge clk);
        chk_ids("afull", {4'd0, 4'd1, 4'd3, 4'd1, 4'd3}, 4);
        chk("afull_wr1", 64'(wr_cnt[1]), 64'd32);
        chk("afull_wr3", 64'(wr_cnt[3]), 64'd32);

        // error response on ch4
        do_reset();
        err_ch = 4; err_beat = 3; err_armed = 1'b1;
        start_chs(5'b10000, 32'h400, 16'd32, 32'd0);
        wait_done(4, 1);
        repeat (5) @(negedge clk);
        chk("err_flag", 64'(ch_err[4]), 64'd1);
        chk("err_done", 64'(done_cnt[4]), 64'd1);
`ifdef FETCH_ERR_ABORT_EN
        chk("err_wr", 64'(wr_cnt[4]), 64'd16);
        chk("err_ar_count", 64'(ar_q.size()), 64'd1);
`else
        chk("err_wr", 64'(wr_cnt[4]), 64'd32);
        chk("err_ar_count", 64'(ar_q.size()), 64'd2);
`endif
        err_ch = -1;
        start_chs(5'b10000, 32'h800, 16'd1, 32'd0);
        @(negedge clk);
        chk("err_cleared_on_start", 64'(ch_err[4]), 64'd0);
        wait_done(4, 2);

        // reset in the middle of a data burst
        do_reset();
        start_chs(5'b00001, 32'h000, 16'd40, 32'd0);
        begin
            int g = 0;
            while (wr_cnt[0] < 3 && g < 200) begin
                @(negedge clk);
                g++;
            end
        end
        @(posedge clk); #1;
        slave_kill = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_arvalid", 64'(arvalid), 64'd0);
        chk("rst_mid_rready", 64'(rready), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_active", 64'(ch_active), 64'd0);
        repeat (5) @(negedge clk);
        chk("rst_mid_no_done", 64'(done_cnt[0]), 64'd0);
        chk("rst_mid_rready_low", 64'(rready), 64'd0);
        clear_stats();
        slave_kill = 1'b0;

        // zero-length start: done next cycle, no AR
        start_chs(5'b00100, 32'h000, 16'd0, 32'd0);
        @(negedge clk);
        chk("len0_done_pulse", 64'(ch_done[2]), 64'd1);
        chk("len0_not_active", 64'(ch_active[2]), 64'd0);
        repeat (10) @(negedge clk);
        chk("len0_done_cycle", 64'(done_cyc[2] - start_ref), 64'd1);
        chk("len0_done_count", 64'(done_cnt[2]), 64'd1);
        chk("len0_no_ar", 64'(ar_q.size()), 64'd0);
        chk("len0_no_arvalid", 64'(arv_cyc), 64'hFFFF_FFFF_FFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
